seg_frame_receiver: RTL

- Display-side receiver for the serial 7-segment stream the counter top emits.
- Each digit has one serial lane. All lanes share one shift clock.
- The block samples the lanes on shift-clock rising edges and reassembles one 8-bit segment byte per digit. It decodes each byte back to a hex nibble and flags patterns it does not recognise.
- Uses: loopback self-check in the counter design, and the front end of a display board.

---
 rtl/seg_frame_receiver.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg_frame_receiver.sv
// ==========================================================================
// seg_frame_receiver: samples DIGITS serial 7-segment lanes on a shared shift
// clock, rebuilds one byte per lane and decodes it to a hex nibble.
// Optional SEG_RX_GAP_TIMEOUT_EN: discard partial frames after an idle gap.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module seg_frame_receiver #(
  parameter int DIGITS     = 3,
  parameter int GAP_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shiftclk_in,
  input  logic [DIGITS-1:0]     seg_in,
  output logic [8*DIGITS-1:0]   seg_byte,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  frame_valid,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Returns {ok, nibble}; dp is excluded by the caller.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic                 sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic [DIGITS-1:0]    seg_s1_q, seg_s2_q;
  state_t               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [8*DIGITS-1:0]  shift_q, shift_d;
  logic [8*DIGITS-1:0]  seg_byte_q, seg_byte_d;
  logic [4*DIGITS-1:0]  digit_val_q, digit_val_d;
  logic [DIGITS-1:0]    digit_ok_q, digit_ok_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 w_edge;

`ifdef SEG_RX_GAP_TIMEOUT_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  logic [GW-1:0]        gap_q, gap_d;
  logic                 frame_err_q, frame_err_d;
`else
  logic                 w_unused_gap;
  assign w_unused_gap = ^GAP_CYCLES;
`endif

  // Data and clock use the same synchroniser depth so each bit stays aligned.
  assign w_edge = sclk_s2_q & ~sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_prev_q   <= 1'b0;
      seg_s1_q      <= '0;
      seg_s2_q      <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= '0;
      seg_byte_q    <= '0;
      digit_val_q   <= '0;
      digit_ok_q    <= '0;
      frame_valid_q <= 1'b0;
`ifdef SEG_RX_GAP_TIMEOUT_EN
      gap_q         <= '0;
      frame_err_q   <= 1'b0;
`endif
    end else begin
      sclk_s1_q     <= shiftclk_in;
      sclk_s2_q     <= sclk_s1_q;
      sclk_prev_q   <= sclk_s2_q;
      seg_s1_q      <= seg_in;
      seg_s2_q      <= seg_s1_q;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      seg_byte_q    <= seg_byte_d;
      digit_val_q   <= digit_val_d;
      digit_ok_q    <= digit_ok_d;
      frame_valid_q <= frame_valid_d;
`ifdef SEG_RX_GAP_TIMEOUT_EN
      gap_q         <= gap_d;
      frame_err_q   <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    seg_byte_d    = seg_byte_q;
    digit_val_d   = digit_val_q;
    digit_ok_d    = digit_ok_q;
    frame_valid_d = 1'b0;

    if (w_edge) begin
      for (int j = 0; j < DIGITS; j++) begin
        shift_d[8*j +: 8] = {shift_q[8*j +: 7], seg_s2_q[j]};
      end
    end

    case (state_q)
      IDLE: begin
        if (w_edge) begin
          bit_cnt_d = 4'd1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_edge) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = DONE;
        end
      end
      DONE: begin
        // Capture uses the pre-shift register; a same-cycle edge starts the next frame.
        seg_byte_d    = shift_q;
        for (int j = 0; j < DIGITS; j++) begin
          {digit_ok_d[j], digit_val_d[4*j +: 4]} = decode(shift_q[8*j +: 7]);
        end
        frame_valid_d = 1'b1;
        bit_cnt_d     = w_edge ? 4'd1 : 4'd0;
        state_d       = w_edge ? SHIFT : IDLE;
      end
      default: begin
        bit_cnt_d = 4'd0;
        state_d   = IDLE;
      end
    endcase

`ifdef SEG_RX_GAP_TIMEOUT_EN
    gap_d       = '0;
    frame_err_d = 1'b0;
    if (state_q == SHIFT && !w_edge) begin
      if (gap_q == GAP_LAST) begin
        shift_d     = '0;
        bit_cnt_d   = 4'd0;
        state_d     = IDLE;
        frame_err_d = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
  end

  assign seg_byte    = seg_byte_q;
  assign digit_val   = digit_val_q;
  assign digit_ok    = digit_ok_q;
  assign frame_valid = frame_valid_q;
`ifdef SEG_RX_GAP_TIMEOUT_EN
  assign frame_err   = frame_err_q;
`else
  assign frame_err   = 1'b0;
`endif

endmodule

`default_nettype wire
